// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: access codes, FSM encodings and code helpers.
// Access codes are nonzero so that mem_ctrl == 0 always means "no RAM operation".
package mem_arbiter_pkg;

  localparam logic [3:0] LB  = 4'h1;
  localparam logic [3:0] LH  = 4'h2;
  localparam logic [3:0] LW  = 4'h3;
  localparam logic [3:0] LBU = 4'h4;
  localparam logic [3:0] LHU = 4'h5;
  localparam logic [3:0] SB  = 4'h9;
  localparam logic [3:0] SH  = 4'hA;
  localparam logic [3:0] SW  = 4'hB;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_ACCESS  = 2'd1;
  localparam logic [1:0] ARB_WAIT_WR = 2'd2;
  localparam logic [1:0] ARB_RESP    = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ARB_IDLE,
    StAccess = ARB_ACCESS,
    StWaitWr = ARB_WAIT_WR,
    StResp   = ARB_RESP
  } arb_state_e;

  function automatic logic is_store(input logic [3:0] ctrl);
    return ctrl[3];
  endfunction

  function automatic logic is_legal(input logic [3:0] ctrl);
    logic legal;
    case (ctrl)
      LB, LH, LW, LBU, LHU, SB, SH, SW: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the data-RAM arbiter: request fields in, grant/done/result out.
interface mem_arbiter_if;
  logic        req;
  logic [3:0]  ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, ctrl, addr, wdata, input gnt, done, rdata, err);
  modport slave  (input req, ctrl, addr, wdata, output gnt, done, rdata, err);
endinterface

// File: rtl/arb_pick.sv
// Combinational two-way picker returning a one-hot grant.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise port 0 has fixed priority.
module arb_pick (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
`ifdef MEM_ARB_RR_EN
    // last_i = 1 means port 1 was served last, so port 0 goes next
    if (req0_i && req1_i) gnt_o = last_i ? 2'b01 : 2'b10;
    else                  gnt_o = {req1_i, req0_i};
`else
    gnt_o = {req1_i && !req0_i, req0_i};
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported data RAM.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WR_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_arbiter_if.slave p0,
  mem_arbiter_if.slave p1,
  output logic [3:0]  mem_ctrl,
  output logic [31:0] rd_addr,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        rd_ready,
  input  logic        wr_ready,
  input  logic [31:0] rd_data,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(WR_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WR_TIMEOUT - 1);

  arb_state_e state_q, state_d;
  logic owner_q, owner_d, err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic cap_en;
  logic [31:0] cap_val;
  logic last;
  logic [1:0] pick;
  logic [3:0] own_ctrl;
  logic [31:0] own_addr, own_wdata;

  assign own_ctrl  = owner_q ? p1.ctrl  : p0.ctrl;
  assign own_addr  = owner_q ? p1.addr  : p0.addr;
  assign own_wdata = owner_q ? p1.wdata : p0.wdata;

  arb_pick u_pick (
    .req0_i(p0.req),
    .req1_i(p1.req),
    .last_i(last),
    .gnt_o (pick)
  );

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign last_d = (state_q == StResp) ? owner_q : last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
  assign last = last_q;
`else
  assign last = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cap_en   = 1'b0;
    cap_val  = '0;
    mem_ctrl = '0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (|pick) begin
          owner_d = pick[1];
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        rd_addr = own_addr;
        wr_addr = own_addr;
        wr_data = own_wdata;
        if (!is_legal(own_ctrl)) begin
          err_d   = 1'b1;
          cap_en  = 1'b1;
          state_d = StResp;
        end else begin
          mem_ctrl = own_ctrl;
          if (is_store(own_ctrl)) begin
            cnt_d   = '0;
            state_d = StWaitWr;
          end else if (rd_ready) begin
            cap_en  = 1'b1;
            cap_val = rd_data;
            state_d = StResp;
          end else if (cnt_q == CntMax) begin
            // a load the RAM never acknowledges shares the write timeout
            err_d   = 1'b1;
            cap_en  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StWaitWr: begin
        rd_addr = own_addr;
        wr_addr = own_addr;
        wr_data = own_wdata;
        if (wr_ready) begin
          state_d = StResp;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (cap_en) begin
      if (owner_q) rdata1_d = cap_val;
      else         rdata0_d = cap_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign p0.gnt   = busy && !owner_q;
  assign p1.gnt   = busy && owner_q;
  assign p0.done  = (state_q == StResp) && !owner_q;
  assign p1.done  = (state_q == StResp) && owner_q;
  assign p0.err   = p0.done && err_q;
  assign p1.err   = p1.done && err_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 128-byte behavioural RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mem_ctrl;
  logic [31:0] rd_addr, wr_addr, wr_data, rd_data;
  logic        rd_ready, wr_ready, busy;

  mem_arbiter_if p0_if ();
  mem_arbiter_if p1_if ();

  mem_arbiter #(.WR_TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p0      (p0_if),
    .p1      (p1_if),
    .mem_ctrl(mem_ctrl),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_ready(rd_ready),
    .wr_ready(wr_ready),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // RAM model: combinational sign/zero-extended reads, write at the edge ending ACCESS
  logic [7:0] ram [128];
  logic [6:0] a0, a1, a2, a3;
  logic       wr_ready_q;
  assign a0 = rd_addr[6:0];
  assign a1 = a0 + 7'd1;
  assign a2 = a0 + 7'd2;
  assign a3 = a0 + 7'd3;
  assign wr_ready = wr_ready_q;

  always_comb begin
    rd_ready = 1'b0;
    rd_data  = '0;
    if (rd_addr < 32'd128) begin
      case (mem_ctrl)
        LB:  begin rd_ready = 1'b1; rd_data = {{24{ram[a0][7]}}, ram[a0]}; end
        LBU: begin rd_ready = 1'b1; rd_data = {24'h0, ram[a0]}; end
        LH:  begin rd_ready = 1'b1; rd_data = {{16{ram[a1][7]}}, ram[a1], ram[a0]}; end
        LHU: begin rd_ready = 1'b1; rd_data = {16'h0, ram[a1], ram[a0]}; end
        LW:  begin rd_ready = 1'b1; rd_data = {ram[a3], ram[a2], ram[a1], ram[a0]}; end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (wr_addr < 32'd128) begin
      case (mem_ctrl)
        SB: ram[wr_addr[6:0]] <= wr_data[7:0];
        SH: begin
          ram[wr_addr[6:0]]         <= wr_data[7:0];
          ram[wr_addr[6:0] + 7'd1]  <= wr_data[15:8];
        end
        SW: begin
          ram[wr_addr[6:0]]         <= wr_data[7:0];
          ram[wr_addr[6:0] + 7'd1]  <= wr_data[15:8];
          ram[wr_addr[6:0] + 7'd2]  <= wr_data[23:16];
          ram[wr_addr[6:0] + 7'd3]  <= wr_data[31:24];
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ready_q <= 1'b0;
    else        wr_ready_q <= mem_ctrl[3] && (wr_addr < 32'd128);
  end

  int checks = 0;
  int failures = 0;
  logic ctrl_nz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; cycle 0 is the current IDLE cycle.
  task automatic run_req(input int port, input logic [3:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, output int cyc, output logic [31:0] rdata,
                         output logic err);
    cyc     = -1;
    rdata   = '0;
    err     = 1'b0;
    ctrl_nz = 1'b0;
    if (port == 0) begin
      p0_if.ctrl = ctrl; p0_if.addr = addr; p0_if.wdata = wdata; p0_if.req = 1'b1;
    end else begin
      p1_if.ctrl = ctrl; p1_if.addr = addr; p1_if.wdata = wdata; p1_if.req = 1'b1;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_ctrl != 4'h0) ctrl_nz = 1'b1;
      if (port == 0 && p0_if.done) begin cyc = c; rdata = p0_if.rdata; err = p0_if.err; break; end
      if (port == 1 && p1_if.done) begin cyc = c; rdata = p1_if.rdata; err = p1_if.err; break; end
    end
    p0_if.req = 1'b0;
    p1_if.req = 1'b0;
    @(posedge clk); #1;
  endtask

  int cyc, t0, t1, nd;
  logic [31:0] rd, r1;
  logic er, done_seen;
  int order [4];

  initial begin
    p0_if.req = 1'b0; p0_if.ctrl = '0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.req = 1'b0; p1_if.ctrl = '0; p1_if.addr = '0; p1_if.wdata = '0;
    for (int i = 0; i < 128; i++) ram[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_p0_flags", {29'h0, p0_if.gnt, p0_if.done, p0_if.err}, 32'h0);
    check("reset_p1_flags", {29'h0, p1_if.gnt, p1_if.done, p1_if.err}, 32'h0);
    check("reset_rdata", p0_if.rdata | p1_if.rdata, 32'h0);
    check("reset_bus", {28'h0, mem_ctrl} | rd_addr | wr_addr | wr_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(0, SW, 32'h10, 32'hDEADBEEF, cyc, rd, er);
    check("sw_p0_cycle", cyc, 3);
    check("sw_p0_err", {31'h0, er}, 32'h0);
    run_req(0, LW, 32'h10, 32'h0, cyc, rd, er);
    check("lw_p0_cycle", cyc, 2);
    check("lw_p0_rdata", rd, 32'hDEADBEEF);
    check("lw_p0_err", {31'h0, er}, 32'h0);

    run_req(1, SB, 32'h21, 32'h80, cyc, rd, er);
    check("sb_p1_cycle", cyc, 3);
    run_req(1, LB, 32'h21, 32'h0, cyc, rd, er);
    check("lb_p1_rdata", rd, 32'hFFFFFF80);
    run_req(1, LBU, 32'h21, 32'h0, cyc, rd, er);
    check("lbu_p1_rdata", rd, 32'h00000080);
    check("lbu_p1_held", p1_if.rdata, 32'h00000080);

    run_req(0, SW, 32'h200, 32'h11223344, cyc, rd, er);
    check("sw_timeout_cycle", cyc, 6);
    check("sw_timeout_err", {31'h0, er}, 32'h1);
    run_req(0, LW, 32'h10, 32'h0, cyc, rd, er);
    check("after_timeout_rdata", rd, 32'hDEADBEEF);

    run_req(1, 4'hF, 32'h10, 32'h0, cyc, rd, er);
    check("illegal_cycle", cyc, 2);
    check("illegal_err", {31'h0, er}, 32'h1);
    check("illegal_rdata", rd, 32'h0);
    check("illegal_ctrl_nz", {31'h0, ctrl_nz}, 32'h0);

    // reset while the store sits in WAIT_WR
    p0_if.ctrl = SW; p0_if.addr = 32'h30; p0_if.wdata = 32'h12345678; p0_if.req = 1'b1;
    @(posedge clk); #1;
    check("mid_access_ctrl", {28'h0, mem_ctrl}, {28'h0, SW});
    check("mid_access_gnt", {30'h0, p1_if.gnt, p0_if.gnt}, 32'h1);
    @(posedge clk); #1;
    check("mid_waitwr_ctrl", {27'h0, busy, mem_ctrl}, 32'h10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {26'h0, busy, p0_if.gnt, p0_if.done, p0_if.err, p1_if.gnt,
                             p1_if.done}, 32'h0);
    check("rst_mid_rdata", p0_if.rdata, 32'h0);
    check("rst_mid_bus", {28'h0, mem_ctrl} | rd_addr | wr_addr | wr_data, 32'h0);
    p0_if.req = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (p0_if.done || p1_if.done) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (p0_if.done || p1_if.done) done_seen = 1'b1;
    end
    check("rst_no_done", {31'h0, done_seen}, 32'h0);
    run_req(1, LW, 32'h10, 32'h0, cyc, rd, er);
    check("post_rst_cycle", cyc, 2);
    check("post_rst_rdata", rd, 32'hDEADBEEF);

    // simultaneous requests: p0 served first, p1 three cycles later
    p0_if.ctrl = LW; p0_if.addr = 32'h10; p0_if.req = 1'b1;
    p1_if.ctrl = LW; p1_if.addr = 32'h20; p1_if.req = 1'b1;
    t0 = -1; t1 = -1; r1 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (p0_if.done) begin t0 = c; p0_if.req = 1'b0; end
      if (p1_if.done) begin t1 = c; r1 = p1_if.rdata; p1_if.req = 1'b0; end
      if (t0 >= 0 && t1 >= 0) break;
    end
    check("both_p0_done", t0, 2);
    check("both_p1_done", t1, 5);
    check("both_p1_rdata", r1, 32'h00008000);
    @(posedge clk); #1;

    // fresh reset, then continuous contention: grant order of four completions
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    p0_if.req = 1'b1; p1_if.req = 1'b1;
    nd = 0;
    for (int c = 1; c <= 30 && nd < 4; c++) begin
      @(posedge clk); #1;
      if (p0_if.done) begin order[nd] = 0; nd++; end
      else if (p1_if.done) begin order[nd] = 1; nd++; end
    end
    p0_if.req = 1'b0; p1_if.req = 1'b0;
    check("order_count", nd, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      check($sformatf("order_%0d", i), order[i], i % 2);
`else
      check($sformatf("order_%0d", i), order[i], 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer in front of the single-ported byte-addressed data RAM. It accepts load/store requests from port 0 (pipeline MEM stage) and port 1 (DMA/debug loader) and grants one at a time. It drives the RAM's `mem_ctrl`/address/data lines for exactly the owned access, waits for RAM completion with a bounded timeout, and returns data, done and error to the owner.

## Interface
Parameters:
- `WR_TIMEOUT`, 4: max cycles spent in WAIT_WR before aborting with error.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` input 1: request; held high with fields stable until `pN_done`.
- `p0_ctrl`, `p1_ctrl` input 4: access code (`LB`/`LBU`/`LH`/`LHU`/`LW`/`SB`/`SH`/`SW` from defines.vh).
- `p0_addr`, `p1_addr` input 32: byte address.
- `p0_wdata`, `p1_wdata` input 32: store data.
- `p0_gnt`, `p1_gnt` output 1: high while that port owns the RAM (ACCESS through RESP).
- `p0_done`, `p1_done` output 1: one-cycle completion pulse.
- `p0_rdata`, `p1_rdata` output 32: load result; valid with done, held until that port's next done.
- `p0_err`, `p1_err` output 1: valid with done; 1 = illegal code or write timeout.
- `mem_ctrl` output 4: to RAM.
- `rd_addr`, `wr_addr` output 32: to RAM.
- `wr_data` output 32: to RAM.
- `rd_ready`, `wr_ready` input 1: from RAM.
- `rd_data` input 32: from RAM, combinational.
- `busy` output 1: state != IDLE.

## Operation
- FSM states: IDLE, ACCESS, WAIT_WR, RESP.
- IDLE: if any `pN_req`, latch owner via picker → ACCESS; else stay.
- ACCESS: `rd_addr` = `wr_addr` = owner addr; `wr_data` = owner wdata; `mem_ctrl` = owner ctrl.
  - Illegal code (not one of the eight) → `mem_ctrl` = 0; go to RESP, err=1, rdata=0.
  - Load with `rd_ready`=1 → capture `rd_data` into owner rdata; go to RESP. Load with `rd_ready`=0 → stay; counts toward timeout.
  - Store (code bit 3 set) → go to WAIT_WR after exactly one cycle.
- WAIT_WR: `mem_ctrl` = 0, addresses held. `wr_ready`=1 → RESP, err=0. Timeout counter reaching `WR_TIMEOUT` → RESP, err=1 (covers addr ≥ 128, which the RAM never acks).
- RESP: `pN_done`=1 for owner; err driven; → IDLE. Timeout counter cleared.
- Outside ACCESS/WAIT_WR: `mem_ctrl`, addresses and `wr_data` are 0.
- Arbitration: fixed priority, port 0 wins when both request (see Configuration).
- Requests are sampled only in IDLE. A req dropped before done is protocol violation; the in-flight access still completes and pulses done.
- The arbiter does not check alignment or address range; the RAM's behaviour applies.

## Timing
- Reset (async assert): state IDLE; all gnt/done/err/busy 0; all rdata 0; `mem_ctrl`/addresses/`wr_data` 0; timeout counter 0; RR pointer selects port 0 next. Reset mid-store: write may or may not land; no done is issued.
- Load: req seen in IDLE cycle 0 → ACCESS cycle 1 → done cycle 2.
- Store: IDLE 0 → ACCESS 1 (RAM writes at end of 1) → WAIT_WR 2 (`wr_ready`=1) → done cycle 3.
- Timeout store: done with err at cycle 2+`WR_TIMEOUT`.
- Requester may drop or change req in cycle after done. Earliest next grant is IDLE on the cycle after RESP. Peak rate is one load per 3 cycles.
- Both req in the same IDLE cycle: winner decided that cycle. Loser waits, with no starvation bound in fixed mode.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. A 1-bit last-owner pointer updates in RESP. On contention, the port not served last wins. After reset, port 0 wins first.
- Undefined: fixed priority, port 0 always wins. The pointer is not built.

## Structure
- Shared defines.vh gains: FSM state encodings (`ARB_IDLE`, `ARB_ACCESS`, `ARB_WAIT_WR`, `ARB_RESP`) and the legal-code check macro (`IS_STORE` = bit 3).
- Access codes come from defines.vh, not redefined locally.
- One sub-module, `arb_pick`: takes two reqs plus the last-owner bit and returns a one-hot grant. It is combinational and contains the `MEM_ARB_RR_EN` logic.

## Test plan
- Port 0 `SW` 0x10 ← 0xDEADBEEF, then `LW` 0x10 → store done cycle 3, err 0; load done cycle 2, rdata 0xDEADBEEF.
- Port 1 `SB` 0x21 ← 0x80, then `LB` 0x21 → rdata 0xFFFFFF80; `LBU` → 0x00000080.
- Both ports req `LW` in the same cycle, fixed mode → p0 done first, p1 done 3 cycles later. With `MEM_ARB_RR_EN` and repeated contention → grants alternate 0,1,0,1.
- Port 0 `SW` to 0x200 → no `wr_ready`; done with err=1 at cycle 2+`WR_TIMEOUT` = 6; memory unchanged.
- Port 1 ctrl 0xF → done cycle 2, err=1, rdata 0, `mem_ctrl` never nonzero.
- `rst_n` low during WAIT_WR → all outputs 0 immediately, no done; next request is served normally.
